alu_issue_stage: RTL
====================

# alu_issue_stage

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It accepts a decoded-register-read instruction, decodes opcode/funct into the ALU's 4-bit control code, and selects and extends operands. It registers the result and presents it to the ALU with a valid/ready handshake. Destination register and write-back enable travel alongside for the EX/MEM stage.

## Interface
- `WORD_SIZE`, 32, operand width
- `CONTROL_SIGNAL_SIZE`, 4, ALU control width
- `clk` input 1 — single clock, all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — upstream offers an instruction
- `in_ready` output 1 — stage can accept this cycle
- `in_instr` input 32 — raw MIPS instruction word
- `in_rs_data` input 32 — register-file value of rs
- `in_rt_data` input 32 — register-file value of rt
- `flush` input 1 — discard all held instructions
- `out_valid` output 1 — ALU operands/control valid
- `out_ready` input 1 — downstream consumes this cycle
- `out_input_a` output 32 — to ALU `input_a`
- `out_input_b` output 32 — to ALU `input_b`
- `out_control` output 4 — to ALU `control`
- `out_dest` output 5 — write-back register number
- `out_wb_en` output 1 — result is written back
- `out_err_illegal` output 1 — instruction not decodable

## Operation
- Transfer occurs on an edge where valid && ready, on either side.
- `out_input_a` = rs_data in all cases.
- R-type (opcode 0x00): `out_input_b` = rt_data. `out_dest` = instr[15:11]. `out_wb_en` = 1.
  - funct 0x20→0x2, 0x21→0x3, 0x22→0x6, 0x23→0x6, 0x24→0x0, 0x25→0x1, 0x27→0xC, 0x2A→0x7.
- I-type: `out_dest` = instr[20:16].
  - addi 0x08→0x2, addiu 0x09→0x3, slti 0x0A→0x7, lw 0x23→0x3: sign-extended imm, wb_en=1.
  - andi 0x0C→0x0, ori 0x0D→0x1: zero-extended imm, wb_en=1.
  - sw 0x2B→0x3: sign-extended imm, wb_en=0.
  - beq 0x04→0x6: b = rt_data, wb_en=0.
- Instruction 0x00000000 (nop): control 0x0, b = rt_data, wb_en=0, illegal=0.
- Any other opcode/funct: `out_err_illegal`=1, control=0xF, wb_en=0. It is still transferred downstream so the ALU reports invalid control and EX/MEM raises the exception.
- `out_dest` forced to 0 whenever `out_wb_en`=0.

## Timing
- Reset: `out_valid`=0, all data outputs=0, buffer empty. `in_ready`=1 with `ISSUE_SKID_EN` defined, otherwise `in_ready`=1 via its combinational expression.
- Latency: accepted on edge N, visible at outputs after edge N, with `out_valid`=1 in cycle N+1.
- Outputs hold stable while `out_valid` && !`out_ready`.
- Order preserved; no instruction dropped or duplicated except by flush.
- `flush` is sampled on the edge. All entries are invalidated, and an instruction offered on that same edge is discarded even if `in_ready`=1. After the edge, `out_valid`=0.
- Reset mid-operation: all entries lost immediately (asynchronous), outputs return to reset values.
- Simultaneous accept and consume with one entry held: new entry replaces output, throughput 1/cycle.

## Configuration
- `ISSUE_SKID_EN` defined: 2-entry skid buffer (main + skid).
  - `in_ready` is a registered flop equal to !skid_full, with no combinational path from `out_ready`.
  - When output is stalled and a word is accepted, it parks in skid. `in_ready` drops the next cycle.
  - When `out_ready` rises, the skid word moves to output on the following edge.
- Not defined: single output register with `in_ready` = !out_valid || out_ready (combinational). Full throughput, combinational ready path.

## Test plan
- Reset: drive rst_n=0 mid-stream → out_valid=0, out_control=0, out_input_a=0 immediately, without waiting for a clock edge.
- R-type decode for `add $3,$1,$2` (0x00221820) with rs=5, rt=7, out_ready=1 → next cycle out_valid=1, a=5, b=7, control=0x2, dest=3, wb_en=1.
- Immediate extension:
  - `addi $4,$1,-1` (0x2024FFFF) → b=0xFFFFFFFF, control=0x2.
  - `ori $4,$1,0xFFFF` (0x3424FFFF) → b=0x0000FFFF, control=0x1.
- Illegal: instr 0xFC000000 → out_err_illegal=1, control=0xF, wb_en=0, dest=0.
- Backpressure: stream 4 instructions with out_ready=0 for 3 cycles.
  - With `ISSUE_SKID_EN`: in_ready falls after 2 accepts.
  - All 4 emerge in order with no loss once out_ready=1.
- Flush: flush=1 on the same edge as an in_valid accept with 2 entries held → out_valid=0 next cycle. The next accepted instruction is the first output.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS opcode/funct into ALU control, selects operands, registers them for the ALU.
// Optional macro ISSUE_SKID_EN adds a skid entry so in_ready is a pure flop; default is a single output register.
module alu_issue_stage #(
    parameter int WORD_SIZE           = 32,
    parameter int CONTROL_SIGNAL_SIZE = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    input  logic [WORD_SIZE-1:0]           in_rs_data,
    input  logic [WORD_SIZE-1:0]           in_rt_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_SIZE-1:0]           out_input_a,
    output logic [WORD_SIZE-1:0]           out_input_b,
    output logic [CONTROL_SIGNAL_SIZE-1:0] out_control,
    output logic [4:0]                     out_dest,
    output logic                           out_wb_en,
    output logic                           out_err_illegal
);

    typedef struct packed {
        logic [WORD_SIZE-1:0]           a;
        logic [WORD_SIZE-1:0]           b;
        logic [CONTROL_SIGNAL_SIZE-1:0] control;
        logic [4:0]                     dest;
        logic                           wb_en;
        logic                           illegal;
    } entry_t;

    entry_t               dec;
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [WORD_SIZE-1:0] imm_sext;
    logic [WORD_SIZE-1:0] imm_zext;

    assign opcode   = in_instr[31:26];
    assign funct    = in_instr[5:0];
    assign imm_sext = {{(WORD_SIZE-16){in_instr[15]}}, in_instr[15:0]};
    assign imm_zext = {{(WORD_SIZE-16){1'b0}}, in_instr[15:0]};

    always_comb begin
        dec         = '0;
        dec.a       = in_rs_data;
        dec.b       = in_rt_data;
        dec.dest    = in_instr[20:16];
        if (in_instr == 32'h0) begin
            dec.control = '0;
        end else if (opcode == 6'h00) begin
            dec.dest  = in_instr[15:11];
            dec.wb_en = 1'b1;
            case (funct)
                6'h20:        dec.control = CONTROL_SIGNAL_SIZE'(4'h2);
                6'h21:        dec.control = CONTROL_SIGNAL_SIZE'(4'h3);
                6'h22, 6'h23: dec.control = CONTROL_SIGNAL_SIZE'(4'h6);
                6'h24:        dec.control = CONTROL_SIGNAL_SIZE'(4'h0);
                6'h25:        dec.control = CONTROL_SIGNAL_SIZE'(4'h1);
                6'h27:        dec.control = CONTROL_SIGNAL_SIZE'(4'hC);
                6'h2A:        dec.control = CONTROL_SIGNAL_SIZE'(4'h7);
                default:      dec.illegal = 1'b1;
            endcase
        end else begin
            dec.wb_en = 1'b1;
            case (opcode)
                6'h08: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h2); dec.b = imm_sext; end
                6'h09: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h3); dec.b = imm_sext; end
                6'h0A: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h7); dec.b = imm_sext; end
                6'h23: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h3); dec.b = imm_sext; end
                6'h0C: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h0); dec.b = imm_zext; end
                6'h0D: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h1); dec.b = imm_zext; end
                6'h2B: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h3); dec.b = imm_sext; dec.wb_en = 1'b0; end
                6'h04: begin dec.control = CONTROL_SIGNAL_SIZE'(4'h6); dec.wb_en = 1'b0; end
                default: dec.illegal = 1'b1;
            endcase
        end
        // Illegal words still travel downstream so EX/MEM can raise the exception.
        if (dec.illegal) begin
            dec.control = '1;
            dec.wb_en   = 1'b0;
        end
        if (!dec.wb_en) dec.dest = '0;
    end

    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;

`ifdef ISSUE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            main_d       = dec;
            main_valid_d = 1'b1;
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign out_valid       = main_valid_q;
    assign out_input_a     = main_q.a;
    assign out_input_b     = main_q.b;
    assign out_control     = main_q.control;
    assign out_dest        = main_q.dest;
    assign out_wb_en       = main_q.wb_en;
    assign out_err_illegal = main_q.illegal;

endmodule
